// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network inference sequencer:
// default network dimensions, the FSM state encoding and the output register index width.
package nn_pkg;

  localparam int N_INPUTS_DEF  = 784;
  localparam int N_OUTPUTS_DEF = 10;
  localparam int OUT_AW        = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } calc_state_t;

endpackage

// File: rtl/calc_addr_gen.sv
// Input, neuron and weight counters for calc_controller, with rollover flags.
// The weight counter runs across neurons, so weights are read neuron-major without a multiplier.
module calc_addr_gen
  import nn_pkg::*;
#(
  parameter int N_INPUTS  = N_INPUTS_DEF,
  parameter int N_OUTPUTS = N_OUTPUTS_DEF,
  parameter int PIX_AW    = $clog2(N_INPUTS),
  parameter int WGT_AW    = $clog2(N_INPUTS * N_OUTPUTS)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr_all,
  input  logic              clr_input,
  input  logic              step,
  input  logic              next_neuron,
  output logic [PIX_AW-1:0] pixel_idx,
  output logic [WGT_AW-1:0] weight_idx,
  output logic [OUT_AW-1:0] neuron_idx,
  output logic              last_input,
  output logic              last_neuron
);

  localparam logic [PIX_AW-1:0] LAST_I = PIX_AW'(N_INPUTS - 1);
  localparam logic [OUT_AW-1:0] LAST_J = OUT_AW'(N_OUTPUTS - 1);

  logic [PIX_AW-1:0] i_r;
  logic [WGT_AW-1:0] w_r;
  logic [OUT_AW-1:0] j_r;

  assign last_input  = (i_r == LAST_I);
  assign last_neuron = (j_r == LAST_J);
  assign pixel_idx   = i_r;
  assign weight_idx  = w_r;
  assign neuron_idx  = j_r;

  // Counter registers; the input index parks on its last value until the next CLEAR.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      i_r <= {PIX_AW{1'b0}};
      w_r <= {WGT_AW{1'b0}};
      j_r <= {OUT_AW{1'b0}};
    end else if (clr_all) begin
      i_r <= {PIX_AW{1'b0}};
      w_r <= {WGT_AW{1'b0}};
      j_r <= {OUT_AW{1'b0}};
    end else begin
      if (clr_input) begin
        i_r <= {PIX_AW{1'b0}};
      end else if (step && !last_input) begin
        i_r <= i_r + PIX_AW'(1'b1);
      end else begin
        i_r <= i_r;
      end

      if (step) begin
        w_r <= w_r + WGT_AW'(1'b1);
      end else begin
        w_r <= w_r;
      end

      if (next_neuron) begin
        j_r <= j_r + OUT_AW'(1'b1);
      end else begin
        j_r <= j_r;
      end
    end
  end

endmodule

// File: rtl/calc_controller.sv
// Sequencer walking every output neuron over every input pixel for the MAC datapath.
// Optional busy-cycle counter enabled by defining CALC_CTRL_PERF_EN.
module calc_controller
  import nn_pkg::*;
#(
  parameter int N_INPUTS  = N_INPUTS_DEF,
  parameter int N_OUTPUTS = N_OUTPUTS_DEF,
  parameter int PIX_AW    = $clog2(N_INPUTS),
  parameter int WGT_AW    = $clog2(N_INPUTS * N_OUTPUTS)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  output logic [PIX_AW-1:0] pixel_address,
  output logic [WGT_AW-1:0] weight_address,
  output logic              rd_en,
  output logic              mac_clear,
  output logic              mac_en,
  output logic              out_wr,
  output logic [OUT_AW-1:0] output_address,
  output logic              busy,
  output logic              done_calc,
  output logic [31:0]       cycle_count
);

  calc_state_t state_r;
  calc_state_t next_state_s;

  logic start_accept_s;
  logic abort_hit_s;
  logic clr_all_s;
  logic clr_input_s;
  logic step_s;
  logic next_neuron_s;
  logic last_input_s;
  logic last_neuron_s;

  assign start_accept_s = (state_r == IDLE) && start && !abort;
  assign abort_hit_s    = (state_r != IDLE) && abort;
  assign clr_all_s      = (state_r == IDLE);
  assign clr_input_s    = (next_state_s == CLEAR);
  assign step_s         = (state_r == ACCUM);
  assign next_neuron_s  = (state_r == STORE) && !last_neuron_s;

  calc_addr_gen #(
    .N_INPUTS  (N_INPUTS),
    .N_OUTPUTS (N_OUTPUTS),
    .PIX_AW    (PIX_AW),
    .WGT_AW    (WGT_AW)
  ) u_addr_gen (
    .clk         (clk),
    .n_rst       (n_rst),
    .clr_all     (clr_all_s),
    .clr_input   (clr_input_s),
    .step        (step_s),
    .next_neuron (next_neuron_s),
    .pixel_idx   (pixel_address),
    .weight_idx  (weight_address),
    .neuron_idx  (output_address),
    .last_input  (last_input_s),
    .last_neuron (last_neuron_s)
  );

  // Next-state logic; abort from any active state overrides the normal walk.
  always_comb begin
    next_state_s = state_r;
    if (abort_hit_s) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_accept_s) begin
            next_state_s = CLEAR;
          end else begin
            next_state_s = IDLE;
          end
        end
        CLEAR: next_state_s = ACCUM;
        ACCUM: begin
          if (last_input_s) begin
            next_state_s = DRAIN;
          end else begin
            next_state_s = ACCUM;
          end
        end
        DRAIN: next_state_s = STORE;
        STORE: begin
          if (last_neuron_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = CLEAR;
          end
        end
        DONE:    next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State register and strobes, registered from the next state so they align with it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= IDLE;
      rd_en     <= 1'b0;
      mac_clear <= 1'b0;
      mac_en    <= 1'b0;
      out_wr    <= 1'b0;
      busy      <= 1'b0;
      done_calc <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      rd_en     <= (next_state_s == ACCUM);
      mac_clear <= (next_state_s == CLEAR);
      out_wr    <= (next_state_s == STORE);
      busy      <= (next_state_s != IDLE);
      // Memory data lands one cycle after rd_en; an abort drops that last beat.
      mac_en    <= rd_en && !abort;
      if (start_accept_s) begin
        done_calc <= 1'b0;
      end else if (next_state_s == DONE) begin
        done_calc <= 1'b1;
      end else begin
        done_calc <= done_calc;
      end
    end
  end

`ifdef CALC_CTRL_PERF_EN
  logic [31:0] cycle_cnt_r;

  // Busy-cycle counter, restarted by each accepted start and frozen while idle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cycle_cnt_r <= 32'd0;
    end else if (start_accept_s) begin
      cycle_cnt_r <= 32'd0;
    end else if (busy) begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  assign cycle_count = cycle_cnt_r;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_calc_controller.sv
// Table-driven bench for calc_controller (N_INPUTS=4, N_OUTPUTS=2) with an address scoreboard.
module tb_calc_controller;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int PER_N = N_IN + 3;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic        abort;
  logic [1:0]  pixel_address;
  logic [2:0]  weight_address;
  logic        rd_en;
  logic        mac_clear;
  logic        mac_en;
  logic        out_wr;
  logic [3:0]  output_address;
  logic        busy;
  logic        done_calc;
  logic [31:0] cycle_count;
  logic [5:0]  obs;

  calc_controller #(.N_INPUTS(N_IN), .N_OUTPUTS(N_OUT)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start          (start),
    .abort          (abort),
    .pixel_address  (pixel_address),
    .weight_address (weight_address),
    .rd_en          (rd_en),
    .mac_clear      (mac_clear),
    .mac_en         (mac_en),
    .out_wr         (out_wr),
    .output_address (output_address),
    .busy           (busy),
    .done_calc      (done_calc),
    .cycle_count    (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, rd_en, mac_clear, mac_en, out_wr, done_calc}
  assign obs = {busy, rd_en, mac_clear, mac_en, out_wr, done_calc};

  typedef struct {
    logic       start;
    logic       abort;
    int         n_rd;
    int         n_wr;
    int         cnt;
    logic [5:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] rd_q[$];
  logic [3:0] wr_q[$];
  int         n_vec;
  int         n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic s, input logic a, input int nr, input int nw,
                              input int cnt, input logic [5:0] e);
    vec_t v;
    v.start = s;
    v.abort = a;
    v.n_rd  = nr;
    v.n_wr  = nw;
    v.cnt   = cnt;
    v.exp   = e;
    tbl.push_back(v);
  endfunction

  // Expected strobes in cycle c (1-based) after an accepted start.
  function automatic logic [5:0] exp_run(input int c);
    logic [5:0] e;
    int         p;
    e = 6'b100000;
    if (c == N_OUT * PER_N + 1) begin
      e[0] = 1'b1;
    end else begin
      p    = (c - 1) % PER_N;
      e[3] = (p == 0);
      e[4] = (p >= 1) && (p <= N_IN);
      e[2] = (p >= 2) && (p <= N_IN + 1);
      e[1] = (p == PER_N - 1);
    end
    return e;
  endfunction

  function automatic int exp_cnt(input int c);
`ifdef CALC_CTRL_PERF_EN
    return c;
`else
    return (c >= 0) ? 0 : 0;
`endif
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    n_rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;

    // Full run, with a start pulse in cycle 5 that must be ignored
    add(1'b1, 1'b0, 8, 2, 0, 6'b000000);
    for (int c = 1; c <= 15; c++) add(c == 5, 1'b0, 0, 0, -1, exp_run(c));
    add(1'b0, 1'b0, 0, 0, 15, 6'b000001);
    // Run aborted in neuron-1 ACCUM (cycle 10)
    add(1'b1, 1'b0, 6, 1, 15, 6'b000001);
    for (int c = 1; c <= 10; c++) add(1'b0, c == 10, 0, 0, (c == 1) ? 0 : -1, exp_run(c));
    // start+abort together in IDLE: abort wins
    add(1'b1, 1'b1, 0, 0, 10, 6'b000000);
    // Restart after abort, weights from 0 again
    add(1'b1, 1'b0, 8, 2, 10, 6'b000000);
    for (int c = 1; c <= 15; c++) add(1'b0, 1'b0, 0, 0, -1, exp_run(c));
    add(1'b0, 1'b0, 0, 0, 15, 6'b000001);

    repeat (2) @(negedge clk);
    chk("reset_strobes", 32'(obs), 32'd0);
    chk("reset_pix", 32'(pixel_address), 32'd0);
    chk("reset_wgt", 32'(weight_address), 32'd0);
    chk("reset_oaddr", 32'(output_address), 32'd0);
    chk("reset_cnt", cycle_count, 32'd0);
    n_rst = 1'b1;

    foreach (tbl[r]) begin
      @(negedge clk);
      chk($sformatf("strobes[%0d]", r), 32'(obs), 32'(tbl[r].exp));
      if (tbl[r].cnt >= 0) chk($sformatf("cycle_count[%0d]", r), cycle_count, 32'(exp_cnt(tbl[r].cnt)));
      if (rd_en) begin
        if (rd_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_extra[%0d]: got pix=%0d wgt=%0d, expected no read", r, pixel_address, weight_address);
        end else begin
          chk($sformatf("rd_addr[%0d]", r), 32'({pixel_address, weight_address}), 32'(rd_q.pop_front()));
        end
      end
      if (out_wr) begin
        if (wr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL wr_extra[%0d]: got addr=%0d, expected no write", r, output_address);
        end else begin
          chk($sformatf("wr_addr[%0d]", r), 32'(output_address), 32'(wr_q.pop_front()));
        end
      end
      start = tbl[r].start;
      abort = tbl[r].abort;
      for (int k = 0; k < tbl[r].n_rd; k++) rd_q.push_back({2'(k % N_IN), 3'(k)});
      for (int k = 0; k < tbl[r].n_wr; k++) wr_q.push_back(4'(k));
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("rd_left", 32'(rd_q.size()), 32'd0);
    chk("wr_left", 32'(wr_q.size()), 32'd0);

    // Reset in the middle of a run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_reset_strobes", 32'(obs), 32'd0);
    chk("mid_reset_wgt", 32'(weight_address), 32'd0);
    chk("mid_reset_cnt", cycle_count, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_strobes", 32'(obs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
